// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M destination tags and result timing,
// raises stall on RAW and HI/LO hazards, and owns the mult/div busy counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_j,
  input  logic       d_r,
  input  logic       d_i,
  input  logic       d_ld,
  input  logic       d_st,
  input  logic       d_jal,
  input  logic       d_mfc0,
  input  logic       d_mtc0,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rd,
  output logic       stall,
  output logic [4:0] e_dst,
  output logic [4:0] m_dst,
  output logic [1:0] e_tnew,
  output logic [1:0] m_tnew,
  output logic       md_busy
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIME_W  = 2;
  localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  logic [REG_W-1:0]  e_dst_q, e_dst_d, m_dst_q, m_dst_d;
  logic [TIME_W-1:0] e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
  logic              e_md_q, e_md_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_busy_q, md_busy_d;

  logic [REG_W-1:0]  d_dst;
  logic [TIME_W-1:0] d_tnew;
  logic              rs_use, rt_use;
  logic [TIME_W-1:0] rs_tuse, rt_tuse;
  logic              raw_hz, md_hz;

  // A source hazards when it is produced in E or M later than D needs it.
  function automatic logic src_hit(input logic [REG_W-1:0] src, input logic used,
                                   input logic [TIME_W-1:0] tuse,
                                   input logic [REG_W-1:0] ed, input logic [TIME_W-1:0] et,
                                   input logic [REG_W-1:0] md, input logic [TIME_W-1:0] mt);
    src_hit = used && (src != '0) &&
              (((src == ed) && (tuse < et)) || ((src == md) && (tuse < mt)));
  endfunction

  always_comb begin
    d_dst   = '0;
    d_tnew  = '0;
    rs_use  = d_j | d_r | d_i | d_ld | d_st;
    rt_use  = d_j | d_r | d_st | d_mtc0;
    rs_tuse = d_j ? TIME_W'(0) : TIME_W'(1);
    rt_tuse = TIME_W'(2);
    if (d_j)      rt_tuse = TIME_W'(0);
    else if (d_r) rt_tuse = TIME_W'(1);

    if (d_r)                        d_dst = d_rd;
    else if (d_i || d_ld || d_mfc0) d_dst = d_rt;
    else if (d_jal)                 d_dst = d_rd;

    if (d_ld || d_mfc0)  d_tnew = TIME_W'(2);
    else if (d_r || d_i) d_tnew = TIME_W'(1);

    raw_hz = src_hit(d_rs, rs_use, rs_tuse, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q) ||
             src_hit(d_rt, rt_use, rt_tuse, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
    md_hz  = d_md_use && (md_busy_q || e_md_q);
    stall  = raw_hz || md_hz;
  end

  // Next-state for the E/M tag records and the mult/div counter.
  always_comb begin
    e_dst_d   = '0;
    e_tnew_d  = '0;
    e_md_d    = 1'b0;
    m_dst_d   = '0;
    m_tnew_d  = '0;
    cnt_d     = cnt_q;

    if (!reset && !flush && !stall) begin
      e_dst_d  = d_dst;
      e_tnew_d = d_tnew;
      e_md_d   = d_md_start;
    end

    if (!reset && !flush) begin
      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q != '0) ? e_tnew_q - TIME_W'(1) : '0;
    end

    if (reset) begin
      cnt_d = '0;
    end else if (flush && e_md_q) begin
      cnt_d = '0;
    end else if (d_md_start && !stall && !flush) begin
      cnt_d = d_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    md_busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst_q   <= '0;
      e_tnew_q  <= '0;
      e_md_q    <= 1'b0;
      m_dst_q   <= '0;
      m_tnew_q  <= '0;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
    end else begin
      e_dst_q   <= e_dst_d;
      e_tnew_q  <= e_tnew_d;
      e_md_q    <= e_md_d;
      m_dst_q   <= m_dst_d;
      m_tnew_q  <= m_tnew_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign e_dst   = e_dst_q;
  assign e_tnew  = e_tnew_q;
  assign m_dst   = m_dst_q;
  assign m_tnew  = m_tnew_q;
  assign md_busy = md_busy_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: short MIPS instruction pairs
// with hand-derived stall/tag expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic       d_j, d_r, d_i, d_ld, d_st, d_jal, d_mfc0, d_mtc0;
  logic       d_md_start, d_md_div, d_md_use;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       stall, md_busy;
  logic [4:0] e_dst, m_dst;
  logic [1:0] e_tnew, m_tnew;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_j(d_j), .d_r(d_r), .d_i(d_i), .d_ld(d_ld), .d_st(d_st), .d_jal(d_jal),
    .d_mfc0(d_mfc0), .d_mtc0(d_mtc0),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .stall(stall), .e_dst(e_dst), .m_dst(m_dst),
    .e_tnew(e_tnew), .m_tnew(m_tnew), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    {d_j, d_r, d_i, d_ld, d_st, d_jal, d_mfc0, d_mtc0} = '0;
    {d_md_start, d_md_div, d_md_use} = '0;
    d_rs = '0; d_rt = '0; d_rd = '0;
    #1;
  endtask

  task automatic drain();
    nop(); tick(); tick(); tick();
  endtask

  task automatic i_lw(input logic [4:0] rt, input logic [4:0] rs);
    nop(); d_ld = 1'b1; d_rt = rt; d_rs = rs; #1;
  endtask

  task automatic i_addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    nop(); d_r = 1'b1; d_rd = rd; d_rs = rs; d_rt = rt; #1;
  endtask

  task automatic i_ori(input logic [4:0] rt, input logic [4:0] rs);
    nop(); d_i = 1'b1; d_rt = rt; d_rs = rs; #1;
  endtask

  task automatic i_md(input logic is_div);
    nop(); d_md_start = 1'b1; d_md_div = is_div; d_md_use = 1'b1; d_rs = 5'd11; d_rt = 5'd12; #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    nop();
    tick(); tick();
    chk("rst_e_dst", 8'(e_dst), 8'd0);
    chk("rst_m_dst", 8'(m_dst), 8'd0);
    chk("rst_e_tnew", 8'(e_tnew), 8'd0);
    chk("rst_m_tnew", 8'(m_tnew), 8'd0);
    chk("rst_md_busy", 8'(md_busy), 8'd0);
    chk("rst_stall", 8'(stall), 8'd0);
    reset = 1'b0;

    // lw $1 ; addu $3,$1,$2 : one stall cycle
    i_lw(5'd1, 5'd2);
    chk("lw_nostall", 8'(stall), 8'd0);
    tick();
    chk("lw_e_dst", 8'(e_dst), 8'd1);
    chk("lw_e_tnew", 8'(e_tnew), 8'd2);
    i_addu(5'd3, 5'd1, 5'd2);
    chk("ld_use_stall", 8'(stall), 8'd1);
    tick();
    chk("ld_use_bubble", 8'(e_dst), 8'd0);
    chk("ld_use_m_dst", 8'(m_dst), 8'd1);
    chk("ld_use_m_tnew", 8'(m_tnew), 8'd1);
    chk("ld_use_release", 8'(stall), 8'd0);
    tick();
    chk("addu_e_dst", 8'(e_dst), 8'd3);
    chk("addu_e_tnew", 8'(e_tnew), 8'd1);
    drain();

    // lw $1 ; beq $1,$2 : two stall cycles
    i_lw(5'd1, 5'd2);
    tick();
    nop(); d_j = 1'b1; d_rs = 5'd1; d_rt = 5'd2; #1;
    chk("beq_stall1", 8'(stall), 8'd1);
    tick();
    chk("beq_stall2", 8'(stall), 8'd1);
    tick();
    chk("beq_release", 8'(stall), 8'd0);
    drain();

    // lw $1 ; sw $1,0($2) : store data is late enough
    i_lw(5'd1, 5'd2);
    tick();
    nop(); d_st = 1'b1; d_rt = 5'd1; d_rs = 5'd2; #1;
    chk("sw_nostall", 8'(stall), 8'd0);
    tick();
    chk("sw_e_dst", 8'(e_dst), 8'd0);
    chk("sw_m_dst", 8'(m_dst), 8'd1);
    drain();

    // ori $1 ; jr $1 : one stall; then jal ; addu $4,$31,$0
    i_ori(5'd1, 5'd2);
    tick();
    nop(); d_j = 1'b1; d_rs = 5'd1; #1;
    chk("jr_stall", 8'(stall), 8'd1);
    tick();
    chk("jr_m_tnew_sat", 8'(m_tnew), 8'd0);
    chk("jr_release", 8'(stall), 8'd0);
    tick();
    nop(); d_jal = 1'b1; d_rd = 5'd31; #1;
    tick();
    chk("jal_e_dst", 8'(e_dst), 8'd31);
    chk("jal_e_tnew", 8'(e_tnew), 8'd0);
    i_addu(5'd4, 5'd31, 5'd0);
    chk("jal_use_nostall", 8'(stall), 8'd0);
    tick();
    chk("after_jal_e_dst", 8'(e_dst), 8'd4);
    chk("after_jal_m_dst", 8'(m_dst), 8'd31);
    chk("after_jal_m_tnew", 8'(m_tnew), 8'd0);
    drain();

    // mult ; mflo (mflo modelled as R-type writing $8)
    for (int k = 0; k < 2; k++) begin
      i_md(k[0]);
      chk("md_start_nostall", 8'(stall), 8'd0);
      tick();
      nop(); d_md_use = 1'b1; d_r = 1'b1; d_rd = 5'd8; #1;
      for (int c = 0; c < ((k == 0) ? 5 : 10); c++) begin
        chk("md_busy_hi", 8'(md_busy), 8'd1);
        chk("md_stall_hi", 8'(stall), 8'd1);
        chk("md_e_bubble", 8'(e_dst), 8'd0);
        tick();
      end
      chk("md_busy_lo", 8'(md_busy), 8'd0);
      chk("md_stall_lo", 8'(stall), 8'd0);
      tick();
      chk("mflo_enters_e", 8'(e_dst), 8'd8);
      drain();
    end

    // flush kills E and M
    i_lw(5'd6, 5'd0);
    tick();
    i_addu(5'd7, 5'd0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_e_dst", 8'(e_dst), 8'd0);
    chk("flush_m_dst", 8'(m_dst), 8'd0);
    chk("flush_m_tnew", 8'(m_tnew), 8'd0);
    drain();

    // flush with mult in E cancels the counter
    i_md(1'b0);
    tick();
    chk("mult_busy_pre_flush", 8'(md_busy), 8'd1);
    nop();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_md_busy", 8'(md_busy), 8'd0);
    nop(); d_md_use = 1'b1; #1;
    chk("mfhi_after_flush", 8'(stall), 8'd0);
    tick();
    chk("mfhi_busy_stays_0", 8'(md_busy), 8'd0);
    drain();

    // reset mid-div clears everything on one edge
    i_lw(5'd9, 5'd0);
    tick();
    i_md(1'b1);
    tick();
    chk("div_busy", 8'(md_busy), 8'd1);
    chk("div_m_dst", 8'(m_dst), 8'd9);
    i_addu(5'd10, 5'd0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_e_dst", 8'(e_dst), 8'd0);
    chk("rst_mid_m_dst", 8'(m_dst), 8'd0);
    chk("rst_mid_e_tnew", 8'(e_tnew), 8'd0);
    chk("rst_mid_m_tnew", 8'(m_tnew), 8'd0);
    chk("rst_mid_md_busy", 8'(md_busy), 8'd0);
    nop(); d_md_use = 1'b1; #1;
    chk("rst_mid_mfhi", 8'(stall), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core, sitting directly downstream of the D-stage instruction classifier. It takes the D-stage class flags and register fields, keeps its own registered record of what the E and M stages will write and when, and raises `stall` on unresolved RAW hazards. It also owns the mult/div busy counter and exports E/M destination tags for the forwarding muxes.

## Interface
- `MULT_CYC`, default 5: busy cycles for mult/multu.
- `DIV_CYC`, default 10: busy cycles for div/divu.

- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  exception/eret flush; kills the instructions in E and M
- `d_j`  in  1  D instruction is a branch, jr or jalr (reads rs, and rt for branches, in D)
- `d_r`  in  1  R-type ALU, excluding jr and jalr
- `d_i`  in  1  I-type ALU
- `d_ld`  in  1  load
- `d_st`  in  1  store
- `d_jal`  in  1  jal or jalr
- `d_mfc0`, `d_mtc0`  in  1 each  CP0 move
- `d_md_start`  in  1  mult/multu/div/divu
- `d_md_div`  in  1  qualifies `d_md_start` as div/divu
- `d_md_use`  in  1  mfhi/mflo/mthi/mtlo/mult/div (needs HI/LO unit)
- `d_rs`, `d_rt`, `d_rd`  in  5 each  D register fields; `d_rd` is already 31 for jal
- `stall`  out  1  combinational; freeze PC/D, insert E bubble
- `e_dst`, `m_dst`  out  5  registered destination of E/M instruction (0 = none)
- `e_tnew`, `m_tnew`  out  2  registered cycles until result available
- `md_busy`  out  1  registered, counter != 0

## Operation
- D destination:
  - `d_r` -> `d_rd`
  - `d_i`, `d_ld`, `d_mfc0` -> `d_rt`
  - `d_jal` -> `d_rd`
  - otherwise 0
- D Tnew at E entry:
  - `d_ld` or `d_mfc0` -> 2
  - `d_r` or `d_i` -> 1
  - `d_jal` -> 0
- Tuse for rs:
  - `d_j` -> 0
  - `d_r`, `d_i`, `d_ld`, `d_st` -> 1
  - otherwise unused
- Tuse for rt:
  - `d_j` -> 0 (jr/jalr: rt unused)
  - `d_r` -> 1
  - `d_st`, `d_mtc0` -> 2
  - otherwise unused
- `stall` is asserted on a RAW hazard: for each used source s != 0, s == `e_dst` and Tuse < `e_tnew`, or s == `m_dst` and Tuse < `m_tnew`.
- `stall` is also asserted on an MD hazard: `d_md_use` and (`md_busy` or E holds an md-start).
- E update on each clock edge, by priority:
  - `reset` or `flush` -> bubble (dst 0, tnew 0, md flag 0)
  - else `stall` -> bubble
  - else load D dst/Tnew/md flag
- M update on each clock edge:
  - `reset` or `flush` -> bubble
  - else `m_dst` <= `e_dst`, `m_tnew` <= `e_tnew` - 1, saturating at 0
- MD counter (4 bits minimum, wide enough for `DIV_CYC`):
  - `reset` -> 0
  - flush while the E md flag is set -> 0 (the mult/div is cancelled)
  - D md-start entering E (no stall, no flush) -> `DIV_CYC` if `d_md_div`, else `MULT_CYC`
  - otherwise, when nonzero -> decrement by 1
- `stall` does not depend on `flush`. The external pipeline gives `flush` priority.

## Timing
- Reset values: `e_dst`, `m_dst`, `e_tnew`, `m_tnew` = 0; counter = 0; `md_busy` = 0. `stall` is therefore 0 whenever no D hazard exists.
- `stall` is zero-latency combinational from the D inputs and the registered state.
- A bubble carries dst 0, so it never matches: rs/rt = 0 never stalls.
- Counter sequence after a mult enters E: 5,4,3,2,1,0. `md_busy` is high for exactly `MULT_CYC` cycles, or `DIV_CYC` for div.
- A new md-start while busy is blocked by `stall` (since `d_md_use` is set). The counter never reloads mid-count.
- Reset mid-operation clears everything on the same edge, regardless of `stall` or `flush`.

## Test plan
- `lw $1` then `addu $3,$1,$2`:
  - `stall` = 1 for exactly 1 cycle (`e_tnew` = 2)
  - then `m_dst` = 1, `m_tnew` = 1 with no stall
- `lw $1` then `beq $1,$2`: `stall` = 1 for 2 cycles, then 0.
- `lw $1` then `sw $1,0($2)` (rt data, Tuse 2): `stall` never asserts.
- `ori $1` then `jr $1`: 1 stall cycle. A `jal` in E makes `e_dst` = 31, `e_tnew` = 0, and a following `addu $4,$31,$0` does not stall.
- `mult` then `mflo`:
  - `md_busy` high 5 cycles, `stall` high 5 cycles
  - `mflo` enters E on the 6th cycle
  - with `div`: 10 cycles
- `mult` enters E and `flush` = 1 in that cycle: counter = 0 next cycle, E/M tags cleared, and a following `mfhi` does not stall. Pulsing `reset` mid-div gives all outputs = 0 on the next edge.
